imem_dmem_arbiter: RTL

Shares one single-port unified memory between the instruction-fetch port (I) and the load/store port (D) of the core. One transaction is outstanding at a time, using a request/grant/response handshake. D has priority over I, and a starvation counter guarantees fetch progress. A flush input lets fetch discard an in-flight instruction response after a branch redirect.

---
 rtl/imem_dmem_arbiter_pkg.sv | 10 +
 rtl/imem_dmem_arbiter_starve_counter.sv | 19 +
 rtl/imem_dmem_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// imem_dmem_arbiter_pkg: shared state/owner encodings and strobe-width helper
package imem_dmem_arbiter_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
    localparam int DEF_DATA_W = 32;
    localparam int STRB_W = DEF_DATA_W / 8;
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/imem_dmem_arbiter_starve_counter.sv
// arb_starve_counter: counts consecutive contested fetch losses, saturating at STARVE_LIMIT
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic loss,
    input  logic clr,
    output logic sat
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (loss && !sat) cnt <= cnt + 1'b1;
    end
    assign sat = cnt == CW'(STARVE_LIMIT);
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory between fetch (I) and load/store (D)
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic                      i_flush,
    output logic                      i_gnt,
    output logic                      i_rvalid,
    output logic [DATA_W-1:0]         i_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_W-1:0]         d_addr,
    input  logic [DATA_W-1:0]         d_wdata,
    input  logic [strb_w(DATA_W)-1:0] d_wstrb,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [DATA_W-1:0]         d_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [strb_w(DATA_W)-1:0] mem_wstrb,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata
);
    state_t state;
    owner_t owner;
    logic   flushed, sat, arb, resp;
    always_comb begin
        arb      = !rst && (state == IDLE || mem_rvalid);
        resp     = !rst && state == BUSY && mem_rvalid;
        i_gnt    = arb && i_req && (!d_req || sat);
        d_gnt    = arb && d_req && !i_gnt;
        mem_req  = i_gnt || d_gnt;
        mem_we   = d_gnt && d_we;
        mem_addr = d_gnt ? d_addr : i_gnt ? i_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        mem_wstrb = d_gnt ? d_wstrb : '0;
        d_rvalid = resp && owner == OWN_D;
        d_rdata  = d_rvalid ? mem_rdata : '0;
        // a flush arriving with the response itself must also drop it
        i_rvalid = resp && owner == OWN_I && !flushed && !i_flush;
        i_rdata  = i_rvalid ? mem_rdata : '0;
    end
    arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk(clk),
        .rst(rst),
        .loss(d_gnt && i_req),
        .clr(i_gnt || !i_req),
        .sat(sat)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            flushed <= 1'b0;
        end else if (mem_req) begin
            state   <= BUSY;
            owner   <= i_gnt ? OWN_I : OWN_D;
            flushed <= 1'b0;
        end else if (resp) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            flushed <= 1'b0;
        end else if (state == BUSY && owner == OWN_I && i_flush) begin
            flushed <= 1'b1;
        end
    end
endmodule
